// File: rtl/i2c_target_mem.sv
// i2c_target_mem: I2C target with a register memory, START/STOP decode, 7-bit address match, pointer/data writes, auto-increment reads
// Ports: ACLK/ARESETn clock and async active-low reset; scl_i/sda_i master bus lines (oversampled);
//        sda_o target data (1 = released); busy START..STOP; wr_strobe/wr_addr/wr_data one pulse per written byte
module i2c_target_mem #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 16,
  localparam int        PTR_W     = $clog2(MEM_DEPTH)
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WR_BYTE   = 3'd3;
  localparam logic [2:0] WR_ACK    = 3'd4;
  localparam logic [2:0] RD_BYTE   = 3'd5;
  localparam logic [2:0] RD_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;
  logic [2:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             first_q, first_d, nack_q, nack_d;
  logic             sda_o_q, sda_o_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       mem_q [MEM_DEPTH];
  logic             rise, fall, start, stop;
  logic [7:0]       byte_in;
  // bits [1:0] synchronise, bit [2] holds the previous synchronised sample for edge detection
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_i};
    sda_sync_d = {sda_sync_q[1:0], sda_i};
    rise       = scl_sync_q[1] & ~scl_sync_q[2];
    fall       = ~scl_sync_q[1] & scl_sync_q[2];
    // SCL must be steady high in both samples, so a coincident SCL edge never yields START/STOP
    start      = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
    stop       = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
    byte_in    = {shift_q[6:0], sda_sync_q[1]};
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    nack_d      = nack_q;
    sda_o_d     = sda_o_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (start) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      sda_o_d = 1'b1;
    end else if (stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sda_o_d = 1'b1;
    end else begin
      case (state_q)
        ADDR:
          if (rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd8) begin
            state_d = shift_q[7:1] == DEV_ADDR ? ADDR_ACK : WAIT_STOP;
            sda_o_d = shift_q[7:1] != DEV_ADDR;
            busy_d  = shift_q[7:1] == DEV_ADDR;
          end
        ADDR_ACK:
          if (fall) begin
            // the R/W bit is still in shift_q[0] from the address phase
            state_d = shift_q[0] ? RD_BYTE : WR_BYTE;
            shift_d = mem_q[ptr_q];
            sda_o_d = shift_q[0] ? mem_q[ptr_q][7] : 1'b1;
            cnt_d   = shift_q[0] ? 4'd1 : 4'd0;
            first_d = 1'b1;
          end
        WR_BYTE:
          if (rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              first_d     = 1'b0;
              wr_strobe_d = !first_q;
              wr_addr_d   = first_q ? wr_addr_q : ptr_q;
              wr_data_d   = first_q ? wr_data_q : byte_in;
              ptr_d       = first_q ? byte_in[PTR_W-1:0] : ptr_q + 1'b1;
            end
          end else if (fall && cnt_q == 4'd8) begin
            state_d = WR_ACK;
            sda_o_d = 1'b0;
          end
        WR_ACK:
          if (fall) begin
            state_d = WR_BYTE;
            sda_o_d = 1'b1;
            cnt_d   = 4'd0;
          end
        RD_BYTE:
          if (fall) begin
            state_d = cnt_q == 4'd8 ? RD_ACK : RD_BYTE;
            sda_o_d = cnt_q == 4'd8 ? 1'b1 : shift_q[6];
            ptr_d   = cnt_q == 4'd8 ? ptr_q + 1'b1 : ptr_q;
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end
        RD_ACK:
          if (rise) nack_d = sda_sync_q[1];
          else if (fall) begin
            state_d = nack_q ? WAIT_STOP : RD_BYTE;
            shift_d = mem_q[ptr_q];
            sda_o_d = nack_q ? 1'b1 : mem_q[ptr_q][7];
            cnt_d   = 4'd1;
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      scl_sync_q  <= 3'b111;
      sda_sync_q  <= 3'b111;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      first_q     <= 1'b0;
      nack_q      <= 1'b1;
      sda_o_q     <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      nack_q      <= nack_d;
      sda_o_q     <= sda_o_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (wr_strobe_d) mem_q[wr_addr_d] <= wr_data_d;
    end
  end
  assign sda_o     = sda_o_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
endmodule

// File: tb/tb_i2c_target_mem.sv
// tb_i2c_target_mem: bit-banged I2C master with a behavioural memory model and strobe scoreboard
module tb_i2c_target_mem;
  localparam int HP = 6;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_o, busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  int         total = 0;
  int         bad = 0;
  logic [7:0]  mem_m [16];
  int          ptr_m = 0;
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        ack_q[$];
  logic        busy_mid, nack_obs, post_obs;

  always #5 clk = ~clk;

  i2c_target_mem #(.DEV_ADDR(7'h50), .MEM_DEPTH(16)) dut (
    .ACLK(clk), .ARESETn(rst_n), .scl_i(scl_m), .sda_i(sda_m),
    .sda_o(sda_o), .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always @(negedge clk) if (wr_strobe) got_q.push_back({wr_addr, wr_data});

  task automatic hp();
    repeat (HP) @(posedge clk);
    #1;
  endtask
  task automatic m_bit(input logic b, output logic o);
    sda_m = b; hp();
    scl_m = 1'b1; hp();
    o = sda_o;
    scl_m = 1'b0; hp();
  endtask
  task automatic m_start();
    sda_m = 1'b1; hp();
    scl_m = 1'b1; hp();
    sda_m = 1'b0; hp();
    scl_m = 1'b0; hp();
  endtask
  task automatic m_stop();
    sda_m = 1'b0; hp();
    scl_m = 1'b1; hp();
    sda_m = 1'b1; hp();
  endtask
  task automatic m_wr(input logic [7:0] b, output logic ack);
    logic o;
    for (int i = 7; i >= 0; i--) m_bit(b[i], o);
    m_bit(1'b1, ack);
  endtask
  task automatic m_rd(input logic nack, output logic [7:0] d, output logic o_ack);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, o);
      d[i] = o;
    end
    m_bit(nack, o_ack);
  endtask

  task automatic do_write(input logic [7:0] p);
    logic a;
    ack_q.delete();
    m_start();
    m_wr(8'hA0, a); ack_q.push_back(a);
    busy_mid = busy;
    m_wr(p, a); ack_q.push_back(a);
    foreach (tx_q[i]) begin
      m_wr(tx_q[i], a);
      ack_q.push_back(a);
    end
    m_stop();
  endtask
  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic a;
    logic [7:0] d;
    rx_q.delete();
    ack_q.delete();
    m_start();
    if (set_ptr) begin
      m_wr(8'hA0, a); ack_q.push_back(a);
      m_wr(p, a); ack_q.push_back(a);
      m_start();
    end
    m_wr(8'hA1, a); ack_q.push_back(a);
    for (int i = 0; i < n; i++) begin
      m_rd(i == n - 1, d, a);
      rx_q.push_back(d);
      nack_obs = a;
    end
    post_obs = sda_o;
    m_stop();
  endtask

  task automatic mdl_write(input logic [7:0] p);
    ptr_m = int'(p) % 16;
    foreach (tx_q[i]) begin
      exp_q.push_back({ptr_m[3:0], tx_q[i]});
      mem_m[ptr_m] = tx_q[i];
      ptr_m = (ptr_m + 1) % 16;
    end
  endtask
  function automatic logic [7:0] mdl_rd();
    logic [7:0] d;
    d = mem_m[ptr_m];
    ptr_m = (ptr_m + 1) % 16;
    return d;
  endfunction
  function automatic int strobe_diff();
    int d;
    d = exp_q.size() != got_q.size() ? 1 : 0;
    if (d == 0) foreach (exp_q[i]) if (exp_q[i] !== got_q[i]) d++;
    exp_q.delete();
    got_q.delete();
    return d;
  endfunction
  function automatic int ack_ones();
    int n = 0;
    foreach (ack_q[i]) if (ack_q[i] !== 1'b0) n++;
    return n;
  endfunction

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    total += 5;
    if (sda_o !== 1'b1) begin bad++; $display("FAIL reset_sda_o got=%b exp=1", sda_o); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
    if (wr_addr !== 4'h0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    rst_n = 1'b1;
    hp();
  endtask

  task automatic test_write();
    tx_q = '{8'hA5, 8'h5A};
    mdl_write(8'h03);
    do_write(8'h03);
    total += 4;
    if (ack_q.size() != 4 || ack_ones() != 0) begin bad++; $display("FAIL write_acks got_nacks=%0d exp=0 of 4", ack_ones()); end
    if (strobe_diff() != 0) begin bad++; $display("FAIL write_strobes got=mismatch exp=(3,A5),(4,5A)"); end
    if (busy_mid !== 1'b1) begin bad++; $display("FAIL write_busy_mid got=%b exp=1", busy_mid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    logic [7:0] e;
    do_read(1'b1, 8'h03, 2);
    ptr_m = 3;
    total += 4;
    if (ack_ones() != 0) begin bad++; $display("FAIL read_acks got_nacks=%0d exp=0", ack_ones()); end
    for (int i = 0; i < 2; i++) begin
      e = mdl_rd();
      total++;
      if (rx_q[i] !== e) begin bad++; $display("FAIL read_byte%0d got=%h exp=%h", i, rx_q[i], e); end
    end
    if (nack_obs !== 1'b1) begin bad++; $display("FAIL read_nack_sda got=%b exp=1", nack_obs); end
    if (post_obs !== 1'b1) begin bad++; $display("FAIL read_post_nack_sda got=%b exp=1", post_obs); end
    if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_bad_addr();
    logic a;
    logic [7:0] e;
    m_start();
    m_wr(8'hA2, a);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL badaddr_ack got=%b exp=1", a); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL badaddr_busy got=%b exp=0", busy); end
    m_wr(8'h03, a);
    m_wr(8'h77, a);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL badaddr_data_ack got=%b exp=1", a); end
    m_stop();
    total++;
    if (strobe_diff() != 0) begin bad++; $display("FAIL badaddr_strobes got=some exp=none"); end
    do_read(1'b1, 8'h03, 1);
    ptr_m = 3;
    e = mdl_rd();
    total++;
    if (rx_q[0] !== e) begin bad++; $display("FAIL badaddr_mem got=%h exp=%h", rx_q[0], e); end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    tx_q = '{8'h11, 8'h22};
    mdl_write(8'h0F);
    do_write(8'h0F);
    total += 2;
    if (ack_ones() != 0) begin bad++; $display("FAIL wrap_acks got_nacks=%0d exp=0", ack_ones()); end
    if (strobe_diff() != 0) begin bad++; $display("FAIL wrap_strobes got=mismatch exp=(F,11),(0,22)"); end
    do_read(1'b1, 8'h0F, 2);
    ptr_m = 15;
    for (int i = 0; i < 2; i++) begin
      e = mdl_rd();
      total++;
      if (rx_q[i] !== e) begin bad++; $display("FAIL wrap_read%0d got=%h exp=%h", i, rx_q[i], e); end
    end
  endtask

  task automatic test_partial_stop();
    logic a;
    logic [7:0] p, e;
    p = 8'($urandom);
    m_start();
    m_wr(8'hA0, a);
    m_wr(p, a);
    ptr_m = int'(p) % 16;
    for (int i = 0; i < 4; i++) m_bit(1'($urandom), a);
    m_stop();
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL partial_busy got=%b exp=0", busy); end
    if (sda_o !== 1'b1) begin bad++; $display("FAIL partial_sda got=%b exp=1", sda_o); end
    if (strobe_diff() != 0) begin bad++; $display("FAIL partial_strobes got=some exp=none"); end
    tx_q = '{8'($urandom)};
    p = 8'($urandom);
    mdl_write(p);
    do_write(p);
    total += 2;
    if (ack_ones() != 0) begin bad++; $display("FAIL partial_next_acks got_nacks=%0d exp=0", ack_ones()); end
    if (strobe_diff() != 0) begin bad++; $display("FAIL partial_next_strobes got=mismatch"); end
    do_read(1'b0, 8'h00, 2);
    for (int i = 0; i < 2; i++) begin
      e = mdl_rd();
      total++;
      if (rx_q[i] !== e) begin bad++; $display("FAIL partial_persist_read%0d got=%h exp=%h", i, rx_q[i], e); end
    end
  endtask

  task automatic test_random();
    logic [7:0] p, e;
    int n;
    bit sp;
    for (int k = 0; k < 10; k++) begin
      p = 8'($urandom);
      n = int'($urandom_range(1, 4));
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      mdl_write(p);
      do_write(p);
      total += 2;
      if (ack_ones() != 0) begin bad++; $display("FAIL rand%0d_wr_acks got_nacks=%0d exp=0", k, ack_ones()); end
      if (strobe_diff() != 0) begin bad++; $display("FAIL rand%0d_strobes got=mismatch", k); end
      sp = 1'($urandom);
      p = 8'($urandom);
      n = int'($urandom_range(1, 4));
      do_read(sp, p, n);
      if (sp) ptr_m = int'(p) % 16;
      for (int i = 0; i < n; i++) begin
        e = mdl_rd();
        total++;
        if (rx_q[i] !== e) begin bad++; $display("FAIL rand%0d_read%0d got=%h exp=%h", k, i, rx_q[i], e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic o;
    logic [7:0] e;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(i == 0 ? 1'b0 : (8'hA0 >> i) & 8'h01, o);
    sda_m = 1'b1;
    hp();
    total++;
    if (sda_o !== 1'b0) begin bad++; $display("FAIL rstmid_ack_driven got=%b exp=0", sda_o); end
    rst_n = 1'b0;
    #1;
    total += 2;
    if (sda_o !== 1'b1) begin bad++; $display("FAIL rstmid_sda got=%b exp=1", sda_o); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    hp();
    rst_n = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    hp();
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    ptr_m = 0;
    do_read(1'b1, 8'h03, 3);
    ptr_m = 3;
    for (int i = 0; i < 3; i++) begin
      e = mdl_rd();
      total++;
      if (rx_q[i] !== e) begin bad++; $display("FAIL rstmid_read%0d got=%h exp=%h", i, rx_q[i], e); end
    end
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_bad_addr();
    test_wrap();
    test_partial_stop();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
